// File: rtl/grid_engine_pkg.sv
// rtl/grid_engine_pkg.sv - shared opcodes, modes, FSM states and status bit positions
package grid_engine_pkg;

    typedef enum logic [3:0] {
        OP_SEL  = 4'd1,
        OP_WR   = 4'd2,
        OP_RD   = 4'd3,
        OP_NEXT = 4'd4,
        OP_MODE = 4'd5,
        OP_STEP = 4'd6,
        OP_RUN  = 4'd7,
        OP_STOP = 4'd8
    } opcode_e;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_ADD  = 2'd1,
        MODE_ROTL = 2'd2,
        MODE_XOR  = 2'd3
    } mode_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_GET_SEL  = 4'd1,
        ST_GET_WR   = 4'd2,
        ST_GET_STEP = 4'd3,
        ST_GET_CNT  = 4'd4,
        ST_RUNNING  = 4'd5
    } state_e;

    localparam int UIO_BUSY_BIT  = 1;
    localparam int UIO_WAIT_BIT  = 2;
    localparam int UIO_ERR_BIT   = 3;
    localparam int UIO_STATE_LSB = 4;

endpackage

// File: rtl/grid_engine_cell.sv
// rtl/grid_engine_cell.sv - one grid cell with reset value, write port and mode update
module grid_engine_cell
    import grid_engine_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             upd_en,
    input  mode_e            mode,
    input  logic [7:0]       step,
    output logic [WIDTH-1:0] value
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] cell_d;
    logic [WIDTH-1:0] cell_q;

    // Next cell value: a host write wins, otherwise apply one update of the global mode
    always_comb begin
        cell_d = cell_q;
        if (wr_en) begin
            cell_d = wr_data;
        end else if (upd_en) begin
            case (mode)
                MODE_ADD:  cell_d = cell_q + WIDTH'(step);
                MODE_ROTL: cell_d = {cell_q[WIDTH-2:0], cell_q[WIDTH-1]};
                MODE_XOR:  cell_d = cell_q ^ {NB{step}};
                default:   cell_d = cell_q;
            endcase
        end
    end

    // Cell storage, reset to its grid-position value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_q <= RESET_VAL;
        end else begin
            cell_q <= cell_d;
        end
    end

    assign value = cell_q;

endmodule

// File: rtl/tt_um_bluewatercrystal_grid_engine.sv
// rtl/tt_um_bluewatercrystal_grid_engine.sv - byte-command grid engine top: sync, decoder FSM, readback, cell array
module tt_um_bluewatercrystal_grid_engine
    import grid_engine_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int NB     = WIDTH / 8;
    localparam int NCELLS = ROWS * COLS;

    // Strobe synchroniser: [0],[1] are the two sync stages, [2] holds the previous synced value
    logic [2:0]       sync_d, sync_q;
    state_e           state_d, state_q;
    logic [3:0]       sel_row_d, sel_row_q;
    logic [3:0]       sel_col_d, sel_col_q;
    logic             sel_err_d, sel_err_q;
    mode_e            mode_d, mode_q;
    logic [7:0]       step_d, step_q;
    logic [WIDTH-1:0] wr_buf_d, wr_buf_q;
    logic [2:0]       wr_cnt_d, wr_cnt_q;
    logic             wr_go_d, wr_go_q;
    logic [WIDTH-1:0] rd_buf_d, rd_buf_q;
    logic [2:0]       rd_idx_d, rd_idx_q;
    logic [7:0]       run_cnt_d, run_cnt_q;
    logic             run_free_d, run_free_q;

    logic             byte_ev;
    logic             stop_ev;
    logic             upd_en;
    logic [7:0]       sel_idx;
    logic [WIDTH-1:0] rd_sel;
    logic [7:0]       uo_byte;
    logic [7:0]       uio_status;
    logic [WIDTH-1:0] cell_val [NCELLS];
    logic             unused_uio;

    assign unused_uio = &{1'b0, uio_in[7:1]};

    assign byte_ev = sync_q[1] & ~sync_q[2] & ena;
    assign stop_ev = byte_ev && (ui_in[3:0] == OP_STOP);
    // The cycle that consumes STOP is still RUNNING but must not update the grid
    assign upd_en  = (state_q == ST_RUNNING) && ena && !stop_ev;
    assign sel_idx = 8'(int'(sel_row_q) * COLS + int'(sel_col_q));

    // Select the addressed cell for RD without indexing past the array bounds
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NCELLS; i++) begin
            if (sel_idx == 8'(i)) begin
                rd_sel = cell_val[i];
            end
        end
    end

    // Readback byte chosen by the current byte index
    always_comb begin
        uo_byte = '0;
        for (int i = 0; i < NB; i++) begin
            if (rd_idx_q == 3'(i)) begin
                uo_byte = rd_buf_q[8*i +: 8];
            end
        end
    end

    // Command decoder FSM: opcode dispatch in IDLE, data-byte collection, run control
    always_comb begin
        sync_d     = {sync_q[1:0], uio_in[0]};
        state_d    = state_q;
        sel_row_d  = sel_row_q;
        sel_col_d  = sel_col_q;
        sel_err_d  = sel_err_q;
        mode_d     = mode_q;
        step_d     = step_q;
        wr_buf_d   = wr_buf_q;
        wr_cnt_d   = wr_cnt_q;
        // A completed WR stays pending while ena is low so the write is never lost
        wr_go_d    = wr_go_q && !ena;
        rd_buf_d   = rd_buf_q;
        rd_idx_d   = rd_idx_q;
        run_cnt_d  = run_cnt_q;
        run_free_d = run_free_q;

        case (state_q)
            ST_IDLE: begin
                if (byte_ev) begin
                    case (ui_in[3:0])
                        OP_SEL:  state_d = ST_GET_SEL;
                        OP_WR: begin
                            state_d  = ST_GET_WR;
                            wr_cnt_d = '0;
                        end
                        OP_RD: begin
                            rd_buf_d = rd_sel;
                            rd_idx_d = '0;
                        end
                        OP_NEXT: begin
                            rd_idx_d = (rd_idx_q == 3'(NB - 1)) ? 3'd0 : rd_idx_q + 3'd1;
                        end
                        OP_MODE: mode_d  = mode_e'(ui_in[5:4]);
                        OP_STEP: state_d = ST_GET_STEP;
                        OP_RUN:  state_d = ST_GET_CNT;
                        default: ;
                    endcase
                end
            end
            ST_GET_SEL: begin
                if (byte_ev) begin
                    state_d = ST_IDLE;
                    if ((int'(ui_in[7:4]) >= ROWS) || (int'(ui_in[3:0]) >= COLS)) begin
                        sel_err_d = 1'b1;
                    end else begin
                        sel_row_d = ui_in[7:4];
                        sel_col_d = ui_in[3:0];
                        sel_err_d = 1'b0;
                    end
                end
            end
            ST_GET_WR: begin
                if (byte_ev) begin
                    for (int i = 0; i < NB; i++) begin
                        if (wr_cnt_q == 3'(i)) begin
                            wr_buf_d[8*i +: 8] = ui_in;
                        end
                    end
                    if (wr_cnt_q == 3'(NB - 1)) begin
                        wr_go_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 3'd1;
                    end
                end
            end
            ST_GET_STEP: begin
                if (byte_ev) begin
                    step_d  = ui_in;
                    state_d = ST_IDLE;
                end
            end
            ST_GET_CNT: begin
                if (byte_ev) begin
                    state_d    = ST_RUNNING;
                    run_cnt_d  = ui_in;
                    run_free_d = (ui_in == 8'd0);
                end
            end
            ST_RUNNING: begin
                if (stop_ev) begin
                    state_d = ST_IDLE;
                end else if (upd_en && !run_free_q) begin
                    run_cnt_d = run_cnt_q - 8'd1;
                    if (run_cnt_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            sel_row_q  <= '0;
            sel_col_q  <= '0;
            sel_err_q  <= 1'b0;
            mode_q     <= MODE_HOLD;
            step_q     <= '0;
            wr_buf_q   <= '0;
            wr_cnt_q   <= '0;
            wr_go_q    <= 1'b0;
            rd_buf_q   <= '0;
            rd_idx_q   <= '0;
            run_cnt_q  <= '0;
            run_free_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            sel_row_q  <= sel_row_d;
            sel_col_q  <= sel_col_d;
            sel_err_q  <= sel_err_d;
            mode_q     <= mode_d;
            step_q     <= step_d;
            wr_buf_q   <= wr_buf_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_go_q    <= wr_go_d;
            rd_buf_q   <= rd_buf_d;
            rd_idx_q   <= rd_idx_d;
            run_cnt_q  <= run_cnt_d;
            run_free_q <= run_free_d;
        end
    end

    // Cell array, each cell resetting to its row-major position
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int IDX = r * COLS + c;
            grid_engine_cell #(
                .WIDTH     (WIDTH),
                .RESET_VAL (WIDTH'(IDX))
            ) u_cell (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (wr_go_q && ena && (sel_idx == 8'(IDX))),
                .wr_data (wr_buf_q),
                .upd_en  (upd_en),
                .mode    (mode_q),
                .step    (step_q),
                .value   (cell_val[IDX])
            );
        end
    end

    // Status byte assembly
    always_comb begin
        uio_status                     = '0;
        uio_status[UIO_BUSY_BIT]       = (state_q == ST_RUNNING);
        uio_status[UIO_WAIT_BIT]       = (state_q == ST_GET_SEL) || (state_q == ST_GET_WR) ||
                                         (state_q == ST_GET_STEP) || (state_q == ST_GET_CNT);
        uio_status[UIO_ERR_BIT]        = sel_err_q;
        uio_status[UIO_STATE_LSB +: 4] = state_q;
    end

    assign uo_out  = uo_byte;
    assign uio_out = uio_status;
    assign uio_oe  = 8'hFE;

endmodule

// File: tb/tb_tt_um_bluewatercrystal_grid_engine.sv
// tb/tb_tt_um_bluewatercrystal_grid_engine.sv - self-checking bench for the grid engine
module tb_tt_um_bluewatercrystal_grid_engine;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int WIDTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int tests = 0;
    int fails = 0;
    int busy_total = 0;

    logic [15:0] m_cell [ROWS*COLS];
    int          m_mode;
    int          m_step;
    int          m_row;
    int          m_col;
    logic        m_err;

    tt_um_bluewatercrystal_grid_engine #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (uio_out[1]) busy_total++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] upd(input logic [15:0] v);
        int x;
        x = int'(v);
        case (m_mode)
            1:       x = (x + m_step) % 65536;
            2:       x = (x * 2 + x / 32768) % 65536;
            3:       x = x ^ (m_step * 257);
            default: x = x;
        endcase
        return 16'(x);
    endfunction

    task automatic model_run(input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < ROWS*COLS; i++) m_cell[i] = upd(m_cell[i]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < ROWS*COLS; i++) m_cell[i] = 16'(i);
        m_mode = 0; m_step = 0; m_row = 0; m_col = 0; m_err = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ui_in     = b;
        uio_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (uio_out[1] && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, uio_out[1], 1'b0);
    endtask

    task automatic cmd_sel(input int r, input int c);
        send_byte(8'h01);
        chk("sel_wait_state", uio_out, {4'h1, m_err, 3'b100});
        send_byte({4'(r), 4'(c)});
        if (r < ROWS && c < COLS) begin
            m_row = r; m_col = c; m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        chk("sel_err", uio_out[3], m_err);
    endtask

    task automatic cmd_wr(input logic [15:0] v);
        send_byte(8'h02);
        send_byte(v[7:0]);
        send_byte(v[15:8]);
        m_cell[m_row*COLS + m_col] = v;
    endtask

    task automatic cmd_mode(input int m);
        send_byte({2'b00, 2'(m), 4'h5});
        m_mode = m;
    endtask

    task automatic cmd_step(input int s);
        send_byte(8'h06);
        send_byte(8'(s));
        m_step = s;
    endtask

    task automatic cmd_run(input int n);
        int start;
        start = busy_total;
        send_byte(8'h07);
        send_byte(8'(n));
        wait_idle("run_timeout");
        chk("run_busy_cycles", 32'(busy_total - start), 32'(n));
        model_run(n);
    endtask

    task automatic check_rd(input string tag);
        logic [15:0] e;
        e = m_cell[m_row*COLS + m_col];
        send_byte(8'h03);
        chk({tag, "_b0"}, uo_out, e[7:0]);
        send_byte(8'h04);
        chk({tag, "_b1"}, uo_out, e[15:8]);
        send_byte(8'h04);
        chk({tag, "_wrap"}, uo_out, e[7:0]);
    endtask

    initial begin
        int start;
        int b;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_uio_out", uio_out, 8'h00);
        chk("uio_oe", uio_oe, 8'hFE);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_uio_out", uio_out, 8'h00);

        // Reset pattern readback and index wrap
        cmd_sel(2, 3);
        check_rd("rd_cell23");

        // Two-byte write, LSB first
        cmd_sel(1, 1);
        cmd_wr(16'hABCD);
        check_rd("rd_written");
        cmd_sel(0, 0);
        check_rd("rd_cell00");

        // Counted ADD run
        cmd_step(5);
        cmd_mode(1);
        cmd_run(3);
        cmd_sel(0, 1);
        check_rd("rd_after_add3");
        chk("add3_literal", {16'h0, m_cell[1]}, 32'h0010);

        // Rotate and XOR
        cmd_sel(0, 2);
        cmd_wr(16'h8001);
        cmd_mode(2);
        cmd_run(1);
        check_rd("rd_rotl");
        cmd_mode(3);
        cmd_step(8'hFF);
        cmd_run(1);
        check_rd("rd_xor");

        // ena low suspends a counted run without leaving RUNNING
        cmd_mode(1);
        cmd_step(3);
        start = busy_total;
        send_byte(8'h07);
        send_byte(8'd20);
        ena = 1'b0;
        repeat (5) @(negedge clk);
        chk("suspend_state", uio_out[7:4], 4'd5);
        chk("suspend_busy", uio_out[1], 1'b1);
        ena = 1'b1;
        wait_idle("suspend_timeout");
        chk("suspend_busy_cycles", 32'(busy_total - start), 32'd25);
        model_run(20);
        check_rd("rd_after_suspend");

        // Free run with a discarded opcode, then STOP
        start = busy_total;
        send_byte(8'h07);
        send_byte(8'h00);
        repeat (4) @(negedge clk);
        send_byte(8'h02);
        chk("free_run_state", uio_out[7:4], 4'd5);
        send_byte(8'h08);
        wait_idle("stop_timeout");
        b = busy_total - start;
        chk("free_run_min10", 32'(b - 1 >= 10), 32'd1);
        model_run(b - 1);
        chk("stop_idle_status", uio_out, {4'h0, m_err, 3'b000});
        check_rd("rd_after_free");
        send_byte(8'h08);
        chk("stop_in_idle", uio_out[7:4], 4'd0);

        // Out-of-range selection
        cmd_sel(9, 0);
        check_rd("rd_after_bad_sel");
        cmd_sel(3, 7);
        cmd_sel(7, 8);
        check_rd("rd_after_bad_col");

        // Randomised command mix against the model
        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 4))
                0: cmd_sel($urandom_range(0, 15), $urandom_range(0, 15));
                1: cmd_wr(16'($urandom));
                2: cmd_step($urandom_range(0, 255));
                3: cmd_mode($urandom_range(0, 3));
                default: cmd_run($urandom_range(1, 5));
            endcase
            cmd_sel($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1));
            check_rd("rd_random");
        end

        // Reset in the middle of a free run
        cmd_mode(1);
        cmd_step(7);
        send_byte(8'h07);
        send_byte(8'h00);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_reset_uio_out", uio_out, 8'h00);
        chk("midrun_reset_uo_out", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("after_reset_uio_out", uio_out, 8'h00);
        cmd_sel(5, 6);
        check_rd("rd_reset_pattern");
        cmd_run(2);
        check_rd("rd_hold_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
